fsm_run_sched: RTL
==================

# fsm_run_sched

Round-robin scheduler that time-shares one run-length detection datapath between `N_CH` serial-bit requesters. Each channel keeps its own context: the expected level `e` and the run counter `c`. The block grants one requester per cycle and updates that channel's context. It reports a registered detect result, `y`, tagged with the channel number. It sits between the per-channel bit sources and the Lab7 FSM result consumers, replacing one dedicated Moore detector per channel.

## Interface
- `N_CH`, 4, number of requesting channels (2..8).
- `RUN_LEN`, 4, consecutive matching samples that complete a run (2..16). Counter width is `CW = $clog2(RUN_LEN)`.
- `CHW`, `$clog2(N_CH)`, channel index width (derived, not overridden).

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_CH  per-channel request; level, held until granted.
- `x`  in  N_CH  per-channel sample bit; valid while `req[i]`=1.
- `clr`  in  N_CH  per-channel synchronous context clear.
- `grant`  out  N_CH  one-hot combinational grant; the sample is accepted on the edge where `req[i]&grant[i]`.
- `y_valid`  out  1  registered; result of the previous cycle's accepted sample.
- `y`  out  1  registered detect flag, qualified by `y_valid`.
- `y_ch`  out  CHW  registered index of the channel that produced the result.
- `y_level`  out  1  registered expected level `e` that the sample was compared against.

## Operation
- Context per channel: `e[i]` (1 bit), `c[i]` (CW bits).
- Arbitration:
  - Eligible set is `req & ~clr`.
  - Round-robin pointer `ptr`. Search order is `ptr`, `ptr+1`, … modulo `N_CH`.
  - The first eligible channel gets `grant`. `grant` is all-zero when none is eligible.
  - After a grant to channel k, `ptr` becomes k+1 mod `N_CH`. With no grant, `ptr` holds.
- Context update for the granted channel k with sample `s = x[k]`:
  - `s==e[k]` and `c[k] < RUN_LEN-1`: `c[k]` increments.
  - `s==e[k]` and `c[k]==RUN_LEN-1`: `e[k]` inverts, `c[k]` becomes 0.
  - `s!=e[k]`: `c[k]` becomes 0, `e[k]` unchanged.
- Result:
  - `y` = 1 if and only if the updated `c[k]` equals `RUN_LEN-1`.
  - `y_level` = `e[k]` before the update.
  - `y_ch` = k.
- Clear: `clr[i]` sets `e[i]`=0 and `c[i]`=0 on the next edge. A cleared channel is never granted in that cycle, so clear always wins over a request.
- Non-granted channels keep their context unchanged.

## Timing
- Reset (`reset_n`=0, asynchronous): all `e`=0, all `c`=0, `ptr`=0. Outputs: `y_valid`=0, `y`=0, `y_ch`=0, `y_level`=0. `grant` is forced to 0 while reset is asserted.
- Reset release mid-run: all contexts restart from 0. No result is produced for samples presented during reset.
- Latency: a sample accepted on edge n drives `y_valid`=1 and its result fields after edge n, i.e. during cycle n+1. With no grant, `y_valid`=0 in the next cycle and `y`, `y_ch`, `y_level` hold their previous values.
- Throughput: one sample per cycle across all channels. A channel that keeps `req` high is granted at least once every `N_CH` cycles.
- Counter wrap: `c` never exceeds `RUN_LEN-1`. The sample after a hit that still matches flips `e` rather than overflowing `c`.
- Single requester: granted every cycle regardless of `ptr`.

## Test plan
- Reset, single channel: `req`=0001 continuous, `x[0]` sequence 0,0,0,0,1,1,1 with `RUN_LEN`=4.
  - `y` = 0,0,1,0,0,0,1.
  - `y_level` = 0,0,0,0,1,1,1.
  - `y_ch`=0 throughout; every result appears one cycle after its grant.
- Mismatch restart: `x[0]` = 0,0,1,0,0,0 → `y` = 0,0,0,0,0,1, and `e[0]` stays 0 after the mismatch.
- Fairness: `req`=1111 for 8 cycles from reset → grant sequence 0001,0010,0100,1000,0001,0010,0100,1000, and `y_ch` = 0,1,2,3,0,1,2,3 lagging by one cycle.
- Clear vs request: `req`=0011, `ptr`=0, `clr`=0001 in the same cycle.
  - `grant`=0010 that cycle.
  - Channel 0 context reads `e`=0, `c`=0 afterwards.
  - Channel 1 is updated normally.
- Async reset mid-run: after 2 matching samples on channel 2, pulse `reset_n` low between edges.
  - Outputs go to 0 immediately.
  - After release, the channel needs 3 fresh matching zeros before `y`=1.
- Idle: `req`=0 → `grant`=0, `y_valid`=0, and `y`, `y_ch`, `y_level` hold their last values.

Source files
------------

// File: rtl/fsm_run_sched.sv
// fsm_run_sched: round-robin run-length detector shared by N_CH channels; in: clock, reset_n, req/x/clr[N_CH]; out: grant[N_CH], y_valid, y, y_ch[CHW], y_level
module fsm_run_sched #(
  parameter int N_CH = 4,
  parameter int RUN_LEN = 4,
  localparam int CHW = $clog2(N_CH),
  localparam int CW = $clog2(RUN_LEN)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] x,
  input  logic [N_CH-1:0] clr,
  output logic [N_CH-1:0] grant,
  output logic            y_valid,
  output logic            y,
  output logic [CHW-1:0]  y_ch,
  output logic            y_level
);
  localparam logic [CW-1:0] TOP = CW'(RUN_LEN - 1);
  logic [N_CH-1:0] e, elig;
  logic [N_CH-1:0][CW-1:0] c;
  logic [CHW-1:0] ptr, k, j, nptr;
  logic any, match, wrap, e_n, hit;
  logic [CW-1:0] c_n;
  assign elig = req & ~clr;
  assign any = |elig;
  always_comb begin
    k = '0;
    j = '0;
    for (int o = N_CH - 1; o >= 0; o--) begin
      j = CHW'((int'(ptr) + o) % N_CH);
      k = elig[j] ? j : k;
    end
  end
  assign grant = (reset_n && any) ? N_CH'(1) << k : '0;
  assign nptr = (k == CHW'(N_CH - 1)) ? '0 : k + CHW'(1);
  assign match = x[k] == e[k];
  assign wrap = c[k] == TOP;
  assign c_n = (match && !wrap) ? c[k] + CW'(1) : '0;
  assign e_n = e[k] ^ (match & wrap);
  assign hit = c_n == TOP;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      e <= '0;
      c <= '0;
      ptr <= '0;
      y_valid <= 1'b0;
      y <= 1'b0;
      y_ch <= '0;
      y_level <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clr[i]) begin
          e[i] <= 1'b0;
          c[i] <= '0;
        end
      end
      y_valid <= any;
      if (any) begin
        e[k] <= e_n;
        c[k] <= c_n;
        ptr <= nptr;
        y <= hit;
        y_ch <= k;
        y_level <= e[k];
      end
    end
  end
endmodule
